// File: rtl/vedic_seq_mul.sv
// Sequential W x W unsigned multiplier: one 8x8 Vedic digit product per clock,
// shifted and accumulated into a 2W-bit accumulator over (W/8)^2 cycles.
module vedic_seq_mul #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);
    localparam int D  = W / 8;
    localparam int N  = D * D;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam int SW = $clog2(2 * W);

    typedef enum logic {IDLE, RUN} state_t;

    // Vedic (Urdhva Tiryagbhyam) building blocks: 2x2 core, composed into 4x4 and 8x8.
    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] r;
        logic       c1;
        r[0] = x[0] & y[0];
        r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1   = x[1] & y[0] & x[0] & y[1];
        r[2] = (x[1] & y[1]) ^ c1;
        r[3] = x[1] & y[1] & c1;
        return r;
    endfunction

    function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vm2(x[1:0], y[1:0]);
        q1 = vm2(x[3:2], y[1:0]);
        q2 = vm2(x[1:0], y[3:2]);
        q3 = vm2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] q0, q1, q2, q3;
        q0 = vm4(x[3:0], y[3:0]);
        q1 = vm4(x[7:4], y[3:0]);
        q2 = vm4(x[3:0], y[7:4]);
        q3 = vm4(x[7:4], y[7:4]);
        return {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
    endfunction

    state_t          state;
    logic [W-1:0]    ra, rb;
    logic [2*W-1:0]  acc;
    logic [IW-1:0]   idx;

    logic [7:0]      a_dig [D];
    logic [7:0]      b_dig [D];
    logic [DW-1:0]   i_sel, j_sel;
    logic [15:0]     term;
    logic [SW-1:0]   shamt;
    logic [2*W-1:0]  shifted;
    logic [2*W-1:0]  acc_sum;

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_dig
            assign a_dig[gi] = ra[8*gi +: 8];
            assign b_dig[gi] = rb[8*gi +: 8];
        end
    endgenerate

    // idx walks the digit pairs row-major: i selects the ra digit, j the rb digit.
    assign i_sel   = DW'(32'(idx) / D);
    assign j_sel   = DW'(32'(idx) % D);
    assign term    = vm8(a_dig[i_sel], b_dig[j_sel]);
    assign shamt   = SW'(8 * (32'(i_sel) + 32'(j_sel)));
    assign shifted = {{(2*W-16){1'b0}}, term} << shamt;
    assign acc_sum = acc + shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            acc   <= '0;
            idx   <= '0;
            ra    <= '0;
            rb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (idx == IW'(N - 1)) begin
                        p     <= acc_sum;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
